// File: rtl/draw_trace_multi_if.sv
// vga_if: pixel stream (raster timing plus colour) passed between overlay stages
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_trace_multi.sv
// draw_trace_multi: pipelined multi-channel trace, border and grid overlay with 3-cycle latency
module draw_trace_multi #(
    parameter int NUM_CH       = 2,
    parameter int SAMPLE_W     = 12,
    parameter int ADDR_W       = 8,
    parameter int H_WIN        = 128,
    parameter int V_BASE       = 600,
    parameter int WIN_W        = 512,
    parameter int WIN_H        = 512,
    parameter int H_DECIM_LOG2 = 1,
    parameter int THICK        = 1,
    parameter int GRID_PITCH   = 64,
    parameter logic [NUM_CH*12-1:0] TRACE_RGB = {12'hf0f, 12'haa0}
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [NUM_CH*ADDR_W-1:0]   sample_addr,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_data,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic signed [ADDR_W-1:0]   x_offset,
    input  logic signed [10:0]         y_offset,
    input  logic [3:0]                 scale_shift,
    input  logic                       grid_en,
    vga_if.slave                       in,
    vga_if.master                      out
);
    localparam logic signed [12:0] Y_TOP = 13'(V_BASE - WIN_H + 1);
    localparam logic signed [12:0] Y_BOT = 13'(V_BASE);
    localparam logic signed [12:0] THK   = 13'(THICK);

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic [10:0] x_rel;
        logic        win_x;
    } pix_t;

    pix_t                     s0, p1, p2;
    logic [ADDR_W-1:0]        addr0;
    logic                     vs_d;
    logic [NUM_CH-1:0]        sh_en;
    logic signed [ADDR_W-1:0] sh_xoff;
    logic signed [10:0]       sh_yoff;
    logic [3:0]               sh_shift;
    logic                     sh_grid;
    logic signed [12:0]       y_raw  [NUM_CH];
    logic signed [12:0]       y_cur  [NUM_CH];
    logic signed [12:0]       y_prev [NUM_CH];
    logic signed [12:0]       y_lnk  [NUM_CH];
    logic signed [12:0]       lo     [NUM_CH];
    logic signed [12:0]       hi     [NUM_CH];
    logic [NUM_CH-1:0]        hit;
    logic signed [12:0]       vc;
    logic [10:0]              v_rel;
    logic                     frame_x, frame_y, win_y, border, grid, blank;
    logic [11:0]              rgb_n;

    // S0: locate the pixel inside the window and form the shared sample address
    always_comb begin
        s0.hcount = in.hcount;
        s0.vcount = in.vcount;
        s0.hsync  = in.hsync;
        s0.vsync  = in.vsync;
        s0.hblnk  = in.hblnk;
        s0.vblnk  = in.vblnk;
        s0.rgb    = in.rgb;
        s0.x_rel  = in.hcount - 11'(H_WIN);
        s0.win_x  = in.hcount >= 11'(H_WIN) && s0.x_rel < 11'(WIN_W);
        addr0     = ADDR_W'(s0.x_rel >> H_DECIM_LOG2) + sh_xoff;
    end

    // frame settings are sampled once per frame on the vsync rising edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d     <= 1'b0;
            sh_en    <= '0;
            sh_xoff  <= '0;
            sh_yoff  <= '0;
            sh_shift <= '0;
            sh_grid  <= 1'b0;
        end else begin
            vs_d <= in.vsync;
            if (in.vsync && !vs_d) begin
                sh_en    <= ch_enable;
                sh_xoff  <= x_offset;
                sh_yoff  <= y_offset;
                sh_shift <= scale_shift;
                sh_grid  <= grid_en;
            end
        end
    end

    // S0->S1->S2 pixel carry while the RAM read is in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1          <= '0;
            p2          <= '0;
            sample_addr <= '0;
        end else begin
            p1          <= s0;
            p2          <= p1;
            sample_addr <= {NUM_CH{addr0}};
        end
    end

    // S2: trace spans linking previous and current column, then colour priority
    always_comb begin
        vc      = 13'(p2.vcount);
        v_rel   = 11'(V_BASE) - p2.vcount;
        frame_x = p2.hcount >= 11'(H_WIN - 1) && p2.hcount <= 11'(H_WIN + WIN_W);
        frame_y = vc >= Y_TOP - 13'sd1 && vc <= Y_BOT + 13'sd1;
        win_y   = vc >= Y_TOP && vc <= Y_BOT;
        border  = frame_x && frame_y && (p2.hcount == 11'(H_WIN - 1) || p2.hcount == 11'(H_WIN + WIN_W) ||
                  vc == Y_TOP - 13'sd1 || vc == Y_BOT + 13'sd1);
        grid    = sh_grid && p2.win_x && win_y &&
                  ((p2.x_rel & 11'(GRID_PITCH - 1)) == '0 || (v_rel & 11'(GRID_PITCH - 1)) == '0);
        blank   = p2.hblnk || p2.vblnk;
        rgb_n   = blank ? p2.rgb : border ? 12'hfff : grid ? 12'h444 : p2.rgb;
        hit     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            y_raw[i] = Y_BOT - 13'(sh_yoff) - 13'(sample_data[i*SAMPLE_W +: SAMPLE_W] >> sh_shift);
            y_cur[i] = y_raw[i] < Y_TOP ? Y_TOP : y_raw[i] > Y_BOT ? Y_BOT : y_raw[i];
            y_lnk[i] = p2.x_rel == '0 ? y_cur[i] : y_prev[i];
            lo[i]    = (y_lnk[i] < y_cur[i] ? y_lnk[i] : y_cur[i]) - THK;
            hi[i]    = (y_lnk[i] > y_cur[i] ? y_lnk[i] : y_cur[i]) + THK;
            hit[i]   = p2.win_x && sh_en[i] && frame_y && vc >= lo[i] && vc <= hi[i];
        end
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (hit[i] && !blank) rgb_n = TRACE_RGB[i*12 +: 12];
    end

    // S3: output register; each channel remembers the height of its last window column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
            for (int i = 0; i < NUM_CH; i++) y_prev[i] <= '0;
        end else begin
            out.hcount <= p2.hcount;
            out.vcount <= p2.vcount;
            out.hsync  <= p2.hsync;
            out.vsync  <= p2.vsync;
            out.hblnk  <= p2.hblnk;
            out.vblnk  <= p2.vblnk;
            out.rgb    <= rgb_n;
            if (p2.win_x)
                for (int i = 0; i < NUM_CH; i++) y_prev[i] <= y_cur[i];
        end
    end
endmodule

// File: tb/tb_draw_trace_multi.sv
// tb_draw_trace_multi: scoreboard bench for the multi-channel trace overlay
module tb_draw_trace_multi;
    localparam int H_WIN  = 128;
    localparam int V_BASE = 600;
    localparam int WIN_W  = 512;
    localparam int Y_TOP  = 89;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       sample_addr;
    logic [23:0]       sample_data;
    logic [1:0]        ch_enable   = '0;
    logic signed [7:0] x_offset    = '0;
    logic signed [10:0] y_offset   = '0;
    logic [3:0]        scale_shift = '0;
    logic              grid_en     = 1'b0;
    logic [11:0]       ram [2][256];
    logic [1:0]        m_en;
    int                m_xoff, m_yoff, m_shift;
    logic              m_grid;
    exp_t              sb[$];
    int                vecs = 0;
    int                errs = 0;
    string             cur = "init";

    vga_if vin();
    vga_if vout();

    draw_trace_multi dut (
        .clk         (clk),
        .rst         (rst),
        .sample_addr (sample_addr),
        .sample_data (sample_data),
        .ch_enable   (ch_enable),
        .x_offset    (x_offset),
        .y_offset    (y_offset),
        .scale_shift (scale_shift),
        .grid_en     (grid_en),
        .in          (vin),
        .out         (vout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) sample_data <= {ram[1][sample_addr[15:8]], ram[0][sample_addr[7:0]]};

    function automatic int ycol(int ch, int xr);
        int a, y;
        a = ((xr >> 1) + m_xoff) & 255;
        y = V_BASE - m_yoff - (int'(ram[ch][a]) >> m_shift);
        return y < Y_TOP ? Y_TOP : y > V_BASE ? V_BASE : y;
    endfunction

    function automatic logic [11:0] model(int h, int v, logic [11:0] rgb, bit blank);
        int xr, yc, yp, lo, hi;
        bit winx, winy, fx, fy;
        xr   = h - H_WIN;
        winx = h >= H_WIN && xr < WIN_W;
        winy = v >= Y_TOP && v <= V_BASE;
        fx   = h >= H_WIN - 1 && h <= H_WIN + WIN_W;
        fy   = v >= Y_TOP - 1 && v <= V_BASE + 1;
        if (blank) return rgb;
        for (int c = 0; c < 2; c++) begin
            if (winx && fy && m_en[c]) begin
                yc = ycol(c, xr);
                yp = xr == 0 ? yc : ycol(c, xr - 1);
                lo = (yp < yc ? yp : yc) - 1;
                hi = (yp > yc ? yp : yc) + 1;
                if (v >= lo && v <= hi) return c == 0 ? 12'haa0 : 12'hf0f;
            end
        end
        if (fx && fy && (h == H_WIN - 1 || h == H_WIN + WIN_W || v == Y_TOP - 1 || v == V_BASE + 1)) return 12'hfff;
        if (m_grid && winx && winy && (xr % 64 == 0 || (V_BASE - v) % 64 == 0)) return 12'h444;
        return rgb;
    endfunction

    task automatic px(int h, int v, bit hs, bit vs, bit hb, bit vb, logic [11:0] rgb);
        exp_t e, o;
        @(negedge clk);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync  = hs;
        vin.vsync  = vs;
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.rgb    = rgb;
        e = '{h: 11'(h), v: 11'(v), hs: hs, vs: vs, hb: hb, vb: vb, rgb: model(h, v, rgb, hb || vb)};
        sb.push_back(e);
        if (sb.size() == 4) begin
            o = sb.pop_front();
            vecs++;
            if (vout.hcount !== o.h || vout.vcount !== o.v || vout.hsync !== o.hs || vout.vsync !== o.vs ||
                vout.hblnk !== o.hb || vout.vblnk !== o.vb || vout.rgb !== o.rgb) begin
                errs++;
                $display("FAIL %s h=%0d v=%0d: got h=%0d v=%0d sync=%b%b blk=%b%b rgb=%h, want sync=%b%b blk=%b%b rgb=%h",
                         cur, o.h, o.v, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk,
                         vout.rgb, o.hs, o.vs, o.hb, o.vb, o.rgb);
            end
        end
    endtask

    task automatic line(int v);
        for (int h = H_WIN - 2; h <= H_WIN + WIN_W + 1; h++) px(h, v, 0, 0, 0, 0, 12'($urandom));
        px(700, v, 1, 0, 1, 0, 12'($urandom));
        px(701, v, 1, 0, 1, 0, 12'($urandom));
    endtask

    task automatic new_frame;
        repeat (2) px(0, 700, 0, 0, 1, 1, 12'($urandom));
        px(0, 701, 0, 1, 1, 1, 12'($urandom));
        m_en = ch_enable; m_xoff = int'(x_offset); m_yoff = int'(y_offset);
        m_shift = int'(scale_shift); m_grid = grid_en;
        px(0, 701, 0, 1, 1, 1, 12'($urandom));
        repeat (2) px(0, 702, 0, 0, 1, 1, 12'($urandom));
    endtask

    task automatic fill(int ch, int split, int lo_val, int hi_val);
        for (int a = 0; a < 256; a++) ram[ch][a] = 12'(a < split ? lo_val : hi_val);
    endtask

    task automatic test_reset;
        cur = "reset";
        repeat (2) @(negedge clk);
        vecs++;
        if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== '0 || sample_addr !== '0) begin
            errs++;
            $display("FAIL reset_state: out=%h addr=%h, want 0", {vout.hcount, vout.vcount, vout.rgb}, sample_addr);
        end
        rst = 1'b0;
        sb.delete();
        m_en = '0; m_xoff = 0; m_yoff = 0; m_shift = 0; m_grid = 1'b0;
        fill(0, 0, 0, 512); fill(1, 0, 0, 512);
        ch_enable = 2'b11; scale_shift = 4'd3; grid_en = 1'b1;
        for (int h = 100; h < 300; h++) px(h, 536, 0, 0, 0, 0, 12'($urandom));
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            vecs++;
            if ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb} !== '0 || sample_addr !== '0) begin
                errs++;
                $display("FAIL reset_midline cyc%0d: out=%h addr=%h, want 0", k, {vout.hcount, vout.vcount, vout.rgb}, sample_addr);
            end
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        sb.delete();
        m_en = '0; m_xoff = 0; m_yoff = 0; m_shift = 0; m_grid = 1'b0;
        cur = "reset_no_trace";
        line(536);
    endtask

    task automatic test_latency;
        cur = "latency";
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0)
                px($urandom_range(0, H_WIN - 2), $urandom_range(0, 1023), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 12'($urandom));
            else
                px($urandom_range(0, 1000), $urandom_range(0, 1023), 1'($urandom), 1'($urandom),
                   1'b1, 1'($urandom), 12'($urandom));
        end
    endtask

    task automatic test_flat;
        int rows[9] = '{88, 300, 534, 535, 536, 537, 538, 600, 601};
        cur = "flat";
        fill(0, 0, 0, 512); fill(1, 0, 0, 0);
        ch_enable = 2'b01; scale_shift = 4'd3; y_offset = '0; x_offset = '0; grid_en = 1'b0;
        new_frame();
        foreach (rows[i]) line(rows[i]);
    endtask

    task automatic test_step;
        int rows[7] = '{98, 99, 100, 101, 600, 601, 602};
        cur = "step_link";
        fill(0, 10, 0, 4000);
        ch_enable = 2'b01; scale_shift = 4'd3; grid_en = 1'b0;
        new_frame();
        foreach (rows[i]) line(rows[i]);
        cur = "step_clamp";
        scale_shift = 4'd0;
        new_frame();
        line(88); line(89); line(90);
    endtask

    task automatic test_pan;
        cur = "pan";
        for (int a = 0; a < 256; a++) ram[0][a] = 12'(a * 8);
        ch_enable = 2'b01; scale_shift = 4'd3; x_offset = -8'sd2; grid_en = 1'b0;
        new_frame();
        line(346); line(347);
        cur = "pan_midframe";
        x_offset = 8'sd5;
        line(346);
        cur = "pan_next_frame";
        new_frame();
        line(346); line(595);
    endtask

    task automatic test_priority;
        cur = "prio_both";
        fill(0, 0, 0, 512); fill(1, 0, 0, 512);
        ch_enable = 2'b11; scale_shift = 4'd3; x_offset = '0; grid_en = 1'b1;
        new_frame();
        line(536); line(540);
        cur = "prio_ch1";
        ch_enable = 2'b10;
        new_frame();
        line(536);
        cur = "prio_grid";
        ch_enable = 2'b00;
        new_frame();
        line(536); line(540);
        cur = "prio_passthru";
        grid_en = 1'b0;
        new_frame();
        line(536);
    endtask

    initial begin
        vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
        vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
        test_reset();
        test_latency();
        test_flat();
        test_step();
        test_pan();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
